mix_columns_seq: RTL and testbench

- Sequential, parametrised MixColumns / InvMixColumns engine for the AES datapath.
- Accepts one 128-bit state and processes COLS_PER_CYCLE columns per clock, computing GF(2^8) products arithmetically (xtime chains) rather than with per-constant lookup tables.
- Serves both the encryption round (forward) and the decryption round (inverse) via a per-transaction mode bit.
- Uses valid/ready handshakes on input and output so it can drop between AddRoundKey and the Sub/Shift stages.

---
 rtl/mix_columns_seq_if.sv | 24 ++
 rtl/mix_columns_seq.sv | 147 ++++++++++++++
 tb/tb_mix_columns_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the MixColumns engine.
//   Sin/Mode/in_valid/in_ready   : input state channel (Mode 0 = forward, 1 = inverse)
//   Sout/out_valid/out_ready     : result state channel
// Byte k of a state is bits [8k:8k+7]; column c is bytes 4c..4c+3, byte 4c in row 0.
// master = producer/consumer side, slave = engine side.
interface mix_columns_seq_if;
    logic [0:127] Sin;
    logic         Mode;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] Sout;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output Sin, Mode, in_valid, out_ready,
        input  in_ready, Sout, out_valid
    );

    modport slave (
        input  Sin, Mode, in_valid, out_ready,
        output in_ready, Sout, out_valid
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Processes COLS_PER_CYCLE columns per busy cycle using xtime chains.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mix_columns_seq_if.slave (Sin, Mode, in_valid, in_ready,
//         Sout, out_valid, out_ready)
// Parameters:
//   COLS_PER_CYCLE : 1, 2 or 4
//   ENABLE_FWD     : 0 drops the forward datapath, engine is inverse-only
//
// state | meaning
// IDLE  | waiting for an input state, in_ready = 1
// BUSY  | transforming one column group per cycle
// DONE  | result held on Sout, out_valid = 1, in_ready follows out_ready
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit ENABLE_FWD     = 1
) (
    input  logic              clk,
    input  logic              rst,
    mix_columns_seq_if.slave  bus
);

    localparam int         N        = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   col_cnt;
    logic [0:127] work_q;
    logic [0:127] sout_q;
    logic         mode_q;
    logic         eff_inv;
    logic         accept;
    logic         last_grp;
    logic         in_ready_c;
    logic         out_valid_c;

    logic [6:0]   grp_base [COLS_PER_CYCLE];
    logic [0:31]  grp_res  [COLS_PER_CYCLE];

    function automatic logic [0:7] xtime(input logic [0:7] x);
        return {x[1:7], 1'b0} ^ (x[0] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [0:31] mix_col(input logic [0:31] a, input logic inv);
        logic [0:7] b  [4];
        logic [0:7] x2 [4];
        logic [0:7] x3 [4];
        logic [0:7] x4 [4];
        logic [0:7] x8 [4];
        logic [0:7] m9 [4];
        logic [0:7] mb [4];
        logic [0:7] md [4];
        logic [0:7] me [4];
        {b[0], b[1], b[2], b[3]} = a;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(b[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            x3[i] = x2[i] ^ b[i];
            m9[i] = x8[i] ^ b[i];
            mb[i] = x8[i] ^ x2[i] ^ b[i];
            md[i] = x8[i] ^ x4[i] ^ b[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv)
            return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        else
            return {x2[0] ^ x3[1] ^ b[2]  ^ b[3],
                    b[0]  ^ x2[1] ^ x3[2] ^ b[3],
                    b[0]  ^ b[1]  ^ x2[2] ^ x3[3],
                    x3[0] ^ b[1]  ^ b[2]  ^ x2[3]};
    endfunction

    // A constant 1 here lets synthesis prune the forward terms entirely.
    assign eff_inv  = ENABLE_FWD ? mode_q : 1'b1;
    assign accept   = bus.in_valid && in_ready_c;
    assign last_grp = (col_cnt == LAST_CNT);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = BUSY;
            BUSY: if (last_grp) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = bus.in_valid ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: in_ready_c = 1'b1;
            DONE: begin
                in_ready_c  = bus.out_ready;
                out_valid_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.Sout      = sout_q;

    // Column group currently addressed by col_cnt
    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            grp_base[g] = 7'((int'(col_cnt) * COLS_PER_CYCLE + g) * 32);
            grp_res[g]  = mix_col(work_q[grp_base[g] +: 32], eff_inv);
        end
    end

    // Work/result registers; work_q and mode_q need no reset since they are
    // always loaded on accept before use.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= 2'd0;
            sout_q  <= '0;
        end else if (accept) begin
            work_q  <= bus.Sin;
            mode_q  <= ENABLE_FWD ? bus.Mode : 1'b1;
            col_cnt <= 2'd0;
        end else if (state == BUSY) begin
            for (int g = 0; g < COLS_PER_CYCLE; g++)
                sout_q[grp_base[g] +: 32] <= grp_res[g];
            col_cnt <= col_cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [0:127] sin_d;
    logic         mode_d;
    logic         ordy;
    logic [3:0]   iv;
    logic [3:0]   ov;
    logic [3:0]   ir;
    logic [0:127] so [4];

    int n_pass  = 0;
    int n_total = 0;

    // Instances: 0 = 1 col/cycle, 1 = 2 col/cycle, 2 = 4 col/cycle, 3 = inverse-only
    mix_columns_seq_if bus0 ();
    mix_columns_seq_if bus1 ();
    mix_columns_seq_if bus2 ();
    mix_columns_seq_if bus3 ();

    assign bus0.Sin = sin_d; assign bus0.Mode = mode_d; assign bus0.out_ready = ordy; assign bus0.in_valid = iv[0];
    assign bus1.Sin = sin_d; assign bus1.Mode = mode_d; assign bus1.out_ready = ordy; assign bus1.in_valid = iv[1];
    assign bus2.Sin = sin_d; assign bus2.Mode = mode_d; assign bus2.out_ready = ordy; assign bus2.in_valid = iv[2];
    assign bus3.Sin = sin_d; assign bus3.Mode = mode_d; assign bus3.out_ready = ordy; assign bus3.in_valid = iv[3];

    assign ov = {bus3.out_valid, bus2.out_valid, bus1.out_valid, bus0.out_valid};
    assign ir = {bus3.in_ready, bus2.in_ready, bus1.in_ready, bus0.in_ready};
    assign so[0] = bus0.Sout;
    assign so[1] = bus1.Sout;
    assign so[2] = bus2.Sout;
    assign so[3] = bus3.Sout;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .ENABLE_FWD(1)) u_c1 (.clk(clk), .rst(rst), .bus(bus0.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(2), .ENABLE_FWD(1)) u_c2 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(4), .ENABLE_FWD(1)) u_c4 (.clk(clk), .rst(rst), .bus(bus2.slave));
    mix_columns_seq #(.COLS_PER_CYCLE(1), .ENABLE_FWD(0)) u_inv (.clk(clk), .rst(rst), .bus(bus3.slave));

    typedef struct {
        int           k;
        logic [0:127] s;
        logic         m;
        logic [0:127] e;
        int           lat;
    } vec_t;

    vec_t tbl [11];

    localparam logic [0:127] INV_IN  = 128'h8e4da1bc_00000000_00000000_00000000;
    localparam logic [0:127] INV_OUT = 128'hdb135345_00000000_00000000_00000000;
    localparam logic [0:127] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [0:127] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [0:127] IO_IN   = 128'h00000000_00000000_4d7ebdf8_00000000;
    localparam logic [0:127] IO_OUT  = 128'h00000000_00000000_2d26314c_00000000;
    localparam logic [0:127] D4_IN   = 128'h00000000_00000000_00000000_d4d4d4d5;
    localparam logic [0:127] D4_OUT  = 128'h00000000_00000000_00000000_d5d5d7d6;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Called at the negedge after an accept edge; cyc = edges until out_valid.
    task automatic wait_out(input int k, output int cyc);
        cyc = 0;
        while (!ov[k] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One isolated transaction; Sin/Mode are scrambled while BUSY.
    task automatic txn(input int k, input logic [0:127] s, input logic m,
                       input logic [0:127] e, input int lat, input string name);
        int cyc;
        sin_d = s; mode_d = m; iv[k] = 1'b1; ordy = 1'b0;
        #1 check({name, ".in_ready"}, 128'(ir[k]), 128'd1);
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0; sin_d = ~s; mode_d = ~m;
        wait_out(k, cyc);
        check({name, ".latency"}, 128'(cyc), 128'(lat));
        check({name, ".sout"}, so[k], e);
        ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check({name, ".drain"}, {126'd0, ov[k], ir[k]}, 128'd1);
    endtask

    initial begin
        logic [0:127] x;
        logic         ok;
        int           c1, c2;

        tbl[0]  = '{0, INV_IN, 1'b1, INV_OUT, 4};
        tbl[1]  = '{1, INV_IN, 1'b1, INV_OUT, 2};
        tbl[2]  = '{2, INV_IN, 1'b1, INV_OUT, 1};
        tbl[3]  = '{0, FWD_IN, 1'b0, FWD_OUT, 4};
        tbl[4]  = '{1, FWD_IN, 1'b0, FWD_OUT, 2};
        tbl[5]  = '{2, FWD_IN, 1'b0, FWD_OUT, 1};
        tbl[6]  = '{0, FWD_OUT, 1'b1, FWD_IN, 4};
        tbl[7]  = '{3, IO_IN, 1'b0, IO_OUT, 4};
        tbl[8]  = '{3, IO_IN, 1'b1, IO_OUT, 4};
        tbl[9]  = '{0, D4_IN, 1'b0, D4_OUT, 4};
        tbl[10] = '{2, FWD_OUT, 1'b1, FWD_IN, 1};

        rst = 1'b1; iv = '0; ordy = 1'b0; sin_d = '0; mode_d = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("reset.out_valid%0d", k), 128'(ov[k]), 128'd0);
            check($sformatf("reset.sout%0d", k), so[k], 128'd0);
            check($sformatf("reset.in_ready%0d", k), 128'(ir[k]), 128'd1);
        end

        for (int i = 0; i < 11; i++)
            txn(tbl[i].k, tbl[i].s, tbl[i].m, tbl[i].e, tbl[i].lat, $sformatf("vec%0d", i));

        // Backpressure: out_ready pulsed in BUSY (no effect), then held low in DONE
        sin_d = FWD_IN; mode_d = 1'b0; iv[0] = 1'b1; ordy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        sin_d = '1; mode_d = 1'b1; iv[0] = 1'b0; ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        wait_out(0, c1);
        check("bp.latency", 128'(c1), 128'd3);
        sin_d = INV_IN; mode_d = 1'b1; iv[0] = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(ov[0] && !ir[0] && so[0] === FWD_OUT)) ok = 1'b0;
        end
        check("bp.hold", 128'(ok), 128'd1);
        check("bp.sout", so[0], FWD_OUT);
        iv[0] = 1'b0; ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("bp.release", {126'd0, ov[0], ir[0]}, 128'd1);

        // Reset while BUSY with col_cnt = 1
        sin_d = FWD_IN; mode_d = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst.out_valid", 128'(ov[0]), 128'd0);
        check("rst.sout", so[0], 128'd0);
        check("rst.in_ready", 128'(ir[0]), 128'd1);
        repeat (5) @(negedge clk);
        check("rst.stay_idle", 128'(ov[0]), 128'd0);
        txn(0, D4_IN, 1'b0, D4_OUT, 4, "rst.next");

        // Back-to-back forward/inverse round trips with no idle cycle
        x = {$urandom, $urandom, $urandom, $urandom};
        sin_d = x; mode_d = 1'b0; iv[0] = 1'b1; ordy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            wait_out(0, c1);
            ok = (c1 == 4);
            sin_d = so[0]; mode_d = 1'b1; iv[0] = 1'b1; ordy = 1'b1;
            #1 if (!ir[0]) ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
            iv[0] = 1'b0; ordy = 1'b0;
            if (ov[0]) ok = 1'b0;
            wait_out(0, c2);
            if (c2 != 4) ok = 1'b0;
            n_total++;
            if (ok && so[0] === x) n_pass++;
            else $display("FAIL roundtrip%0d: got %h lat %0d/%0d expected %h lat 4/4", i, so[0], c1, c2, x);
            if (i < 999) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                sin_d = x; mode_d = 1'b0; iv[0] = 1'b1; ordy = 1'b1;
                @(posedge clk);
                @(negedge clk);
                iv[0] = 1'b0; ordy = 1'b0;
            end else begin
                ordy = 1'b1;
                @(negedge clk);
                ordy = 1'b0;
            end
        end
        check("final.idle", {126'd0, ov[0], ir[0]}, 128'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
